// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package inst_mem_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_e;

    localparam int unsigned NOP_WORD_DEF = 0;

    // Ceiling log2 usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single-port synchronous RAM; write and read never coincide, so one port suffices.
module inst_mem_array #(
    parameter int unsigned INST_W = 16,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADR_W  = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADR_W-1:0]  wadr_i,
    input  logic [INST_W-1:0] wdata_i,
    input  logic [ADR_W-1:0]  radr_i,
    output logic [INST_W-1:0] rdata_o
);

    logic [INST_W-1:0] mem_q [DEPTH];

    // No reset: contents survive rst, and the read register is masked by the top.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wadr_i] <= wdata_i;
        end else begin
            rdata_o <= mem_q[radr_i];
        end
    end

endmodule

// File: rtl/inst_mem_loadable.sv
// Instruction memory with fetch port and run-time boot-load handshake.
module inst_mem_loadable
    import inst_mem_pkg::*;
#(
    parameter int unsigned       INST_W   = 16,
    parameter int unsigned       DEPTH    = 256,
    parameter int unsigned       ADR_W    = 8,
    parameter int unsigned       LOAD_LEN = 256,
    parameter logic [INST_W-1:0] NOP_WORD = INST_W'(NOP_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADR_W-1:0]  fetch_adr,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              busy,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [INST_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done
);

    localparam int unsigned      CNT_W    = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_hit_q, rd_hit_d;
    logic               inst_valid_q, inst_valid_d;
    logic               busy_q, busy_d;
    logic               ld_ready_q, ld_ready_d;
    logic               ld_done_q, ld_done_d;
    logic               we_c;
    logic               fetch_ok_c;
    logic               in_range_c;
    logic [INST_W-1:0]  rdata;

    inst_mem_array #(
        .INST_W(INST_W),
        .DEPTH (DEPTH),
        .ADR_W (ADR_W)
    ) u_array (
        .clk    (clk),
        .we_i   (we_c),
        .wadr_i (ADR_W'(cnt_q)),
        .wdata_i(ld_data),
        .radr_i (fetch_adr),
        .rdata_o(rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ld_done_d    = 1'b0;
        we_c         = 1'b0;
        fetch_ok_c   = fetch_en && (state_q == RUN);
        in_range_c   = ({1'b0, fetch_adr} < (ADR_W + 1)'(DEPTH));

        case (state_q)
            RUN: begin
                if (ld_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    we_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d   = RUN;
                        ld_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase

        inst_valid_d = fetch_ok_c;
        rd_hit_d     = fetch_ok_c && in_range_c;
        busy_d       = (state_d == LOAD);
        ld_ready_d   = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            rd_hit_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ld_ready_q   <= 1'b0;
            ld_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_hit_q     <= rd_hit_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
            ld_ready_q   <= ld_ready_d;
            ld_done_q    <= ld_done_d;
        end
    end

    // RAM read register selected by a resettable hit flag, so inst is NOP right at reset.
    assign inst       = rd_hit_q ? rdata : NOP_WORD;
    assign inst_valid = inst_valid_q;
    assign busy       = busy_q;
    assign ld_ready   = ld_ready_q;
    assign ld_done    = ld_done_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Randomised bench for inst_mem_loadable against a word-array reference model.
module tb_inst_mem_loadable;

    localparam int unsigned DEPTH = 200;

    logic        clk;
    logic        rst;
    logic        fe [2];
    logic [7:0]  fa [2];
    logic        ls [2];
    logic        lv [2];
    logic [15:0] ld [2];
    logic [15:0] inst_o [2];
    logic        val_o [2];
    logic        busy_o [2];
    logic        rdy_o [2];
    logic        done_o [2];

    // Instance 0: short 4-word bursts; instance 1: full-depth burst.
    inst_mem_loadable #(.INST_W(16), .DEPTH(DEPTH), .ADR_W(8), .LOAD_LEN(4), .NOP_WORD(16'h0000)) dut0 (
        .clk(clk), .rst(rst), .fetch_en(fe[0]), .fetch_adr(fa[0]), .inst(inst_o[0]),
        .inst_valid(val_o[0]), .busy(busy_o[0]), .ld_start(ls[0]), .ld_valid(lv[0]),
        .ld_data(ld[0]), .ld_ready(rdy_o[0]), .ld_done(done_o[0]));

    inst_mem_loadable #(.INST_W(16), .DEPTH(DEPTH), .ADR_W(8), .LOAD_LEN(DEPTH), .NOP_WORD(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .fetch_en(fe[1]), .fetch_adr(fa[1]), .inst(inst_o[1]),
        .inst_valid(val_o[1]), .busy(busy_o[1]), .ld_start(ls[1]), .ld_valid(lv[1]),
        .ld_data(ld[1]), .ld_ready(rdy_o[1]), .ld_done(done_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int done_cnt [2];

    // Reference model: memory contents, burst progress and expected outputs.
    logic [15:0] mem_m [2][256];
    bit          load_m [2];
    int          cnt_m  [2];
    logic [15:0] e_inst [2];
    bit          e_val  [2];
    bit          e_busy [2];
    bit          e_done [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int burst_len(input int k);
        return (k == 0) ? 4 : int'(DEPTH);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            load_m[k] = 1'b0;
            cnt_m[k]  = 0;
            e_inst[k] = 16'h0;
            e_val[k]  = 1'b0;
            e_busy[k] = 1'b0;
            e_done[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        bit          v;
        logic [15:0] d;
        v = !load_m[k] && fe[k];
        d = 16'h0;
        if (v && (int'(fa[k]) < int'(DEPTH))) d = mem_m[k][fa[k]];
        e_done[k] = 1'b0;
        if (load_m[k]) begin
            if (lv[k]) begin
                mem_m[k][cnt_m[k]] = ld[k];
                cnt_m[k]++;
                if (cnt_m[k] == burst_len(k)) begin
                    load_m[k] = 1'b0;
                    e_done[k] = 1'b1;
                end
            end
        end else if (ls[k]) begin
            load_m[k] = 1'b1;
            cnt_m[k]  = 0;
        end
        e_busy[k] = load_m[k];
        e_val[k]  = v;
        e_inst[k] = d;
    endtask

    task automatic check_outputs(input int k);
        check($sformatf("i%0d.inst", k),     32'(inst_o[k]), 32'(e_inst[k]));
        check($sformatf("i%0d.valid", k),    32'(val_o[k]),  32'(e_val[k]));
        check($sformatf("i%0d.busy", k),     32'(busy_o[k]), 32'(e_busy[k]));
        check($sformatf("i%0d.ld_ready", k), 32'(rdy_o[k]),  32'(e_busy[k]));
        check($sformatf("i%0d.ld_done", k),  32'(done_o[k]), 32'(e_done[k]));
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            check_outputs(k);
            if (done_o[k] === 1'b1) done_cnt[k]++;
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            fe[k] = 1'b0; fa[k] = 8'h0; ls[k] = 1'b0; lv[k] = 1'b0; ld[k] = 16'h0;
        end
    endtask

    // Assert rst between edges and expect the outputs to drop at once.
    task automatic async_reset();
        clear_inputs();
        #3 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) check_outputs(k);
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
        #2 rst = 1'b0;

        // Directed 4-word burst with a 2-cycle gap, a fetch and a stray ld_start inside it.
        ls[0] = 1'b1; tick(); ls[0] = 1'b0;
        lv[0] = 1'b1; ld[0] = 16'h9E01; tick();
        ld[0] = 16'h9C08; tick();
        lv[0] = 1'b0; fe[0] = 1'b1; fa[0] = 8'd0; ls[0] = 1'b1; tick();
        ls[0] = 1'b0; tick();
        fe[0] = 1'b0; lv[0] = 1'b1; ld[0] = 16'h9A09; tick();
        ld[0] = 16'h63F0; tick();
        lv[0] = 1'b0; tick();
        check("i0.done_cnt", 32'(done_cnt[0]), 32'd1);

        fe[0] = 1'b1;
        for (int a = 0; a < 4; a++) begin
            fa[0] = 8'(a);
            tick();
        end
        check("i0.word3", 32'(inst_o[0]), 32'h63F0);
        fe[0] = 1'b0; tick();

        // Restart with a concurrent fetch, then reset after two of four words.
        ls[0] = 1'b1; fe[0] = 1'b1; fa[0] = 8'd3; tick();
        ls[0] = 1'b0; fe[0] = 1'b0; lv[0] = 1'b1; ld[0] = 16'($urandom); tick();
        ld[0] = 16'($urandom); tick();
        async_reset();
        tick();
        check("i0.done_after_rst", 32'(done_cnt[0]), 32'd1);
        fe[0] = 1'b1;
        for (int a = 0; a < 4; a++) begin
            fa[0] = 8'(a);
            tick();
        end
        fe[0] = 1'b0; tick();

        // Full-depth burst on instance 1 with random ld_valid gaps and blocked fetches.
        ls[1] = 1'b1; tick(); ls[1] = 1'b0;
        for (int c = 0; c < 3000 && load_m[1]; c++) begin
            lv[1] = ($urandom_range(3) != 0);
            ld[1] = 16'($urandom);
            fe[1] = 1'($urandom);
            fa[1] = 8'($urandom);
            tick();
        end
        lv[1] = 1'b0; fe[1] = 1'b0; tick();
        check("i1.done_cnt", 32'(done_cnt[1]), 32'd1);

        // Random fetch traffic incl. out-of-range addresses and random reloads on instance 0.
        for (int c = 0; c < 400; c++) begin
            ls[0] = ($urandom_range(19) == 0);
            lv[0] = 1'($urandom);
            ld[0] = 16'($urandom);
            fe[0] = ($urandom_range(3) != 0);
            fa[0] = ($urandom_range(1) == 0) ? 8'($urandom_range(3)) : 8'($urandom_range(255, 200));
            fe[1] = ($urandom_range(3) != 0);
            if (c == 0) fa[1] = 8'd199;
            else if (c == 1) fa[1] = 8'd250;
            else fa[1] = 8'($urandom);
            if (c < 2) fe[1] = 1'b1;
            tick();
        end
        clear_inputs();
        lv[0] = 1'b1;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
Parametrised successor to the fixed instruction ROM. It is a synchronous-read instruction memory that the CPU fetch stage reads each cycle. Its contents are streamed in at run time through a boot-load handshake, driven from the off-chip memory controller or a host, instead of being hard-coded. A small FSM arbitrates between fetch (RUN) and load (LOAD) and stalls fetch while a load is in progress.

Parameters:
INST_W, 16, instruction word width in bits
DEPTH, 256, number of instruction words (need not be a power of two)
ADR_W, 8, fetch address width; must satisfy 2**ADR_W >= DEPTH
LOAD_LEN, 256, words written per load burst; 1 <= LOAD_LEN <= DEPTH
NOP_WORD, 0, value driven on inst when there is no valid fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  fetch request for this cycle
fetch_adr  in  ADR_W  word address of the fetch
inst  out  INST_W  registered instruction word
inst_valid  out  1  inst holds mem[fetch_adr] from the previous cycle's accepted fetch
busy  out  1  high while in LOAD; fetch stage must stall
ld_start  in  1  single-cycle request to begin a load burst
ld_valid  in  1  ld_data is valid
ld_data  in  INST_W  word to write
ld_ready  out  1  block accepts ld_data this cycle
ld_done  out  1  one-cycle pulse after the final word is written

Behaviour:
- Reset (async, rst=1): state=RUN, load counter=0, inst=NOP_WORD, inst_valid=0, busy=0, ld_ready=0, ld_done=0. The memory array is not cleared and keeps its contents across reset.
- States: RUN, LOAD.
- RUN -> LOAD on ld_start=1; the counter is cleared to 0 on entry.
- LOAD -> RUN on the cycle after the word with counter==LOAD_LEN-1 is accepted.
- In LOAD, ld_start is ignored; no restart or abort is possible except by rst.
- busy=1 and ld_ready=1 exactly when state==LOAD. Both are registered state decodes.
- Load transfer occurs when ld_valid && ld_ready at a clk edge: mem[cnt]<=ld_data, cnt<=cnt+1. ld_valid may deassert for any number of cycles; no write and no counter advance occur in those cycles.
- The counter width is clog2(DEPTH+1). The counter never exceeds LOAD_LEN-1, so it has no wrap.
- ld_done pulses high for one cycle, the cycle after the last write, coincident with state==RUN.
- Fetch is accepted when fetch_en=1 and state==RUN (sampled at the edge). On the next cycle, inst=mem[fetch_adr] and inst_valid=1. Latency is 1 cycle and a new fetch may be accepted every cycle.
- Fetch not accepted (fetch_en=0, or state==LOAD): the next cycle has inst=NOP_WORD and inst_valid=0.
- Out of range: fetch_adr >= DEPTH returns inst=NOP_WORD with inst_valid=1. This only applies when DEPTH is not a power of two.
- ld_start and fetch_en both high in RUN: the fetch is accepted and its data returns on the first LOAD cycle. Reads and writes never conflict because writes occur only in LOAD.
- Reset during LOAD: returns to RUN with no ld_done pulse. Words already written remain; the rest keep their old contents.
- Uninitialised words (never loaded since power-up) read as X in simulation. The bench must load before reading.

Decomposition:
- Shared package inst_mem_pkg: state enum (RUN, LOAD), NOP_WORD default, and a clog2 helper/localparam for the counter width.
- One sub-module, inst_mem_array: single-port synchronous RAM parametrised by INST_W, DEPTH and ADR_W, with we/wadr/wdata and radr/rdata. Because write and read are mutually exclusive by state, it maps to a single M4K/M9K port on the DE2.
- The FSM, counter, output registers and range check live in the top module.

Test Plan:
- Reset: assert rst mid-cycle (async) -> inst=0, inst_valid=0, busy=0, ld_ready=0, ld_done=0 immediately.
- Load with LOAD_LEN=4: ld_start, then words 16'h9E01, 16'h9C08, 16'h9A09, 16'h63F0, with ld_valid low for 2 cycles after the 2nd word -> ld_ready=1 throughout LOAD, exactly 4 writes, ld_done pulses once on the cycle after the 4th write, busy drops the same cycle.
- Fetch after the load: fetch_en=1 with adr 0,1,2,3 back-to-back -> inst=9E01, 9C08, 9A09, 63F0 on consecutive cycles each one cycle later, with inst_valid=1. fetch_en=0 -> inst=0, inst_valid=0.
- Fetch during load: fetch_en=1, adr=0 while busy=1 -> inst_valid=0 and inst=0. A ld_start pulse mid-burst does not reset the counter; the total write count stays 4.
- Reset mid-load: after 2 of 4 words, pulse rst -> state RUN and no ld_done. Fetch adr 0,1 returns the new words; adr 2,3 return the previously loaded values.
- DEPTH=200, ADR_W=8: fetch adr 8'd250 -> inst=0, inst_valid=1. Fetch adr 8'd199 returns mem[199].
